reg_write_arbiter: RTL and testbench

- Shares the single write port of the 8x8 register file between two requesters: port 0 is the CPU datapath writeback, port 1 is the debug/loader port.
- Adds a hardware clear sequencer that zeroes all registers one per cycle, driven through the same write port.
- Sits directly in front of the register file and drives its IN, INADDRESS and WRITEENABLE inputs.
- Read ports are not touched.

---
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the 8x8 register file: round-robin between the datapath
// and debug ports, plus a hardware clear sequencer that zeroes every register.
module reg_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] DATA0,
  output logic                  ACK0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DATA1,
  output logic                  ACK1,
  input  logic                  CLEAR,
  output logic                  BUSY,
  output logic                  WRITEENABLE,
  output logic [ADDR_WIDTH-1:0] INADDRESS,
  output logic [DATA_WIDTH-1:0] IN
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] CntOne   = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {StArb, StClr} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_rr;       // 0: port 0 wins a tie, 1: port 1 wins a tie
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_busy;

  logic w_grant0;
  logic w_grant1;

  always_comb begin
    w_grant0 = REQ0 & (~REQ1 | ~r_rr);
    w_grant1 = REQ1 & (~REQ0 |  r_rr);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StArb;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StArb: begin
          if (CLEAR) begin
            // Clear wins over pending requests; address 0 is written on this edge.
            r_state <= StClr;
            r_cnt   <= CntOne;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
            if (w_grant0) begin
              r_we   <= 1'b1;
              r_addr <= ADDR0;
              r_data <= DATA0;
              r_ack0 <= 1'b1;
              r_ack1 <= 1'b0;
              r_rr   <= 1'b1;
            end else if (w_grant1) begin
              r_we   <= 1'b1;
              r_addr <= ADDR1;
              r_data <= DATA1;
              r_ack0 <= 1'b0;
              r_ack1 <= 1'b1;
              r_rr   <= 1'b0;
            end else begin
              // Idle: address and data hold their last values.
              r_we   <= 1'b0;
              r_ack0 <= 1'b0;
              r_ack1 <= 1'b0;
            end
          end
        end
        StClr: begin
          r_we   <= 1'b1;
          r_addr <= r_cnt;
          r_data <= '0;
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_busy <= 1'b1;
          if (r_cnt == LastAddr) begin
            r_state <= StArb;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        default: begin
          r_state <= StArb;
          r_cnt   <= '0;
          r_we    <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign WRITEENABLE = r_we;
  assign INADDRESS   = r_addr;
  assign IN          = r_data;
  assign ACK0        = r_ack0;
  assign ACK1        = r_ack1;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus queues expected writes, a monitor
// pops and compares every cycle the DUT presents a write or an acknowledge.
module tb_reg_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, clear;
  logic [2:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy, we;
  logic [2:0] waddr;
  logic [7:0] wdata;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       ack0;
    logic       ack1;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_write_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .NUM_REGS  (8)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .REQ0       (req0),
    .ADDR0      (addr0),
    .DATA0      (data0),
    .ACK0       (ack0),
    .REQ1       (req1),
    .ADDR1      (addr1),
    .DATA1      (data1),
    .ACK1       (ack1),
    .CLEAR      (clear),
    .BUSY       (busy),
    .WRITEENABLE(we),
    .INADDRESS  (waddr),
    .IN         (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d,
                      input logic k0, input logic k1, input logic b);
    exp_t e;
    e.addr = a; e.data = d; e.ack0 = k0; e.ack1 = k1; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int first, input int last);
    for (int i = first; i <= last; i++) push(3'(i), 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (we || ack0 || ack1)) begin
      if (ack0 || ack1) check("one_ack_only", {31'd0, ack0 & ack1}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {29'd0, waddr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_en",   {31'd0, we},    32'd1);
        check("wr_addr", {29'd0, waddr}, {29'd0, e.addr});
        check("wr_data", {24'd0, wdata}, {24'd0, e.data});
        check("ack0",    {31'd0, ack0},  {31'd0, e.ack0});
        check("ack1",    {31'd0, ack1},  {31'd0, e.ack1});
        check("busy",    {31'd0, busy},  {31'd0, e.busy});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; clear = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_we"},   {31'd0, we},   32'd0);
    check({name, "_ack0"}, {31'd0, ack0}, 32'd0);
    check({name, "_ack1"}, {31'd0, ack1}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    check_quiet("rst");
    check("rst_addr", {29'd0, waddr}, 32'd0);
    check("rst_data", {24'd0, wdata}, 32'd0);
    tick(2);
    rst_n = 1;
    tick(1);
  endtask

  task automatic wait_ack(input int port, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1);
      if ((port == 0 && ack0) || (port == 1 && ack1)) got = 1;
    end
    check(port == 0 ? "ack0_seen" : "ack1_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(2);
    check_quiet("init");
    rst_n = 1;
    tick(1);

    // Idle after reset: nothing happens for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      check_quiet("idle");
      tick(1);
    end

    // Single port-0 write, then idle holds address/data.
    req0 = 1; addr0 = 3'd3; data0 = 8'h5A;
    push(3'd3, 8'h5A, 1'b1, 1'b0, 1'b0);
    wait_ack(0, 4);
    req0 = 0;
    tick(1);
    check_quiet("after_single");
    check("hold_addr", {29'd0, waddr}, 32'd3);
    check("hold_data", {24'd0, wdata}, 32'h5A);
    check("q_single", exp_q.size(), 32'd0);

    // Both ports held: strict alternation 0,1,0,1 from a fresh pointer.
    do_reset();
    req0 = 1; addr0 = 3'd1; data0 = 8'h11;
    req1 = 1; addr1 = 3'd2; data1 = 8'h22;
    for (int i = 0; i < 2; i++) begin
      push(3'd1, 8'h11, 1'b1, 1'b0, 1'b0);
      push(3'd2, 8'h22, 1'b0, 1'b1, 1'b0);
    end
    tick(4);
    req0 = 0; req1 = 0;
    tick(2);
    check_quiet("after_rr");
    check("q_rr", exp_q.size(), 32'd0);

    // Clear pulse with port 1 pending: 8 clear writes, then the deferred grant.
    do_reset();
    clear = 1;
    req1 = 1; addr1 = 3'd7; data1 = 8'hFF;
    push_clear(0, 7);
    push(3'd7, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick(1);
    clear = 0;
    wait_ack(1, 12);
    req1 = 0;
    tick(1);
    check_quiet("after_clr");
    check("q_clr", exp_q.size(), 32'd0);

    // Reset while address 4 is being cleared aborts the sequence.
    do_reset();
    clear = 1;
    push_clear(0, 4);
    tick(1);
    clear = 0;
    tick(4);
    @(negedge clk);
    #1;
    do_reset();
    tick(12);
    check("q_abort", exp_q.size(), 32'd0);
    clear = 1;
    push_clear(0, 7);
    tick(1);
    clear = 0;
    tick(10);
    check_quiet("after_reclr");
    check("q_reclr", exp_q.size(), 32'd0);

    // CLEAR held 20 cycles: sequences run back to back, third one completes.
    do_reset();
    clear = 1;
    push_clear(0, 7);
    push_clear(0, 7);
    push_clear(0, 7);
    tick(20);
    clear = 0;
    tick(5);
    check_quiet("after_held");
    check("q_held", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
